ps2_cmd_scheduler: RTL and testbench
====================================

// Module: ps2_cmd_scheduler
// PURPOSE
//  Arbitrates host-to-keyboard PS/2 commands (LED set, typematic, reset, scan-set) from
//  several requesters onto the single PS/2 send/receive channel. Sequences request-to-send,
//  byte transmit, ACK/RESEND handling, retry and timeout. Passes scancodes through otherwise.
//  Sits between the PS/2 bit transceiver and the keyboard decoder / LED / OSD logic.
// PARAMETERS
//  NREQ       3       number of requesters (2..4)
//  RTS_CYC    710     clk7_en ticks the PS/2 clock is held low before a send (~100us)
//  TMO_CYC    131072  clk7_en ticks to wait for transmit completion or a response (~18ms)
//  MAX_RETRY  2       resends per byte before the command fails
// PORTS
//  clk          in   1        bus clock
//  clk7_en      in   1        7MHz clock enable; all state advances only when high
//  reset_n      in   1        asynchronous, active-low reset
//  req          in   NREQ     level request per requester; held until done
//  cmd          in   8*NREQ   command byte per requester ([8i+7:8i])
//  arg          in   8*NREQ   argument byte per requester
//  has_arg      in   NREQ     1 = command takes an argument byte
//  done         out  NREQ     one-tick pulse to the served requester at completion
//  fail         out  1        qualifies done: 1 = retries exhausted
//  ps2clk_hold  out  1        1 = transceiver drives PS/2 clock low (inhibit/RTS)
//  tx_start     out  1        one-tick pulse: transceiver sends tx_byte
//  tx_byte      out  8        byte to send; stable from tx_start until tx_done
//  tx_done      in   1        one-tick pulse: device clocked in all bits
//  rx_valid     in   1        one-tick pulse: rx_byte holds a received byte
//  rx_byte      in   8        received byte
//  rx_busy      in   1        receive frame in progress
//  scan_valid   out  1        one-tick pulse: scan_byte forwarded to the keyboard decoder
//  scan_byte    out  8        forwarded byte
// BEHAVIOUR
//  Reset (reset_n=0, async): state IDLE, RR pointer 0, retry count 0; all outputs 0.
//  States: IDLE, RTS, SEND, WAIT_TX, WAIT_RSP, DONE.
//  IDLE: rx_valid -> scan_valid=1 and scan_byte=rx_byte on the next tick. If any req=1 and
//   rx_busy=0, grant round-robin: search starts at index (last granted+1) mod NREQ. Latch
//   cmd/arg/has_arg of the winner, set phase=CMD, retry=0, go RTS. Two-tick latency
//   from req to ps2clk_hold=1.
//  RTS: ps2clk_hold=1, count RTS_CYC ticks, then go SEND.
//  SEND: ps2clk_hold=0, tx_start=1 for one tick, tx_byte = cmd (phase CMD) or arg (phase ARG).
//   Go to WAIT_TX.
//  WAIT_TX: tx_done -> WAIT_RSP with the timer cleared. TMO_CYC with no tx_done -> counts as a
//   resend.
//  WAIT_RSP outcomes:
//   - 0xFA: if phase=CMD and has_arg, set phase=ARG, retry=0, go RTS. Otherwise go DONE.
//   - 0xFE, or TMO_CYC elapses: if retry<MAX_RETRY, increment retry and go RTS (same byte).
//     Otherwise go DONE with fail=1.
//   - Any other byte: forward as a scancode (scan_valid) and stay. The timer is not cleared.
//   - 0xAA after cmd 0xFF is handled by the requester (forwarded after DONE).
//  DONE: pulse done[winner] and fail for one tick, update RR pointer, go IDLE.
//  Timer: 18-bit, cleared on every state entry, saturates.
//  Edge cases:
//   - rx_valid in RTS/SEND/WAIT_TX is forwarded as a scancode.
//   - A requester dropping req mid-command is ignored; the command completes and done still
//     pulses.
//   - New req during a command waits; there is no pre-emption.
//   - req from all requesters at once is served in order ptr, ptr+1, ...
//   - Reset mid-command aborts with no done pulse; ps2clk_hold is released immediately.
// TESTING
//  1. NREQ=3, req[1]=1 cmd=0xF4, no arg; device ACKs 0xFA -> one tx_start with tx_byte=0xF4;
//     done=3'b010 with fail=0; ps2clk_hold held exactly 710 ticks.
//  2. req[0] cmd=0xED arg=0x05; ACK both -> tx_byte 0xED then 0x05, two RTS windows; done[0]
//     once, after the second 0xFA.
//  3. req[2] cmd=0xED; reply 0xFE three times -> 0xED sent three times; done[2]=1 with fail=1;
//     arg never sent.
//  4. req=3'b111 held, all ACK -> grant order 0,1,2, then 0 again; each done one tick wide.
//  5. In IDLE inject rx 0x1C, then during WAIT_RSP inject 0x32 then 0xFA -> scan_valid for 0x1C
//     and 0x32 only; 0xFA consumed.
//  6. Assert reset_n=0 mid-RTS -> ps2clk_hold=0 asynchronously; no done; after release, IDLE
//     and re-grant from index 0.

Source files
------------

// File: rtl/ps2_cmd_scheduler_if.sv
// Bundle of the requester, PS/2 transceiver and scancode signals around ps2_cmd_scheduler.
// master is the scheduler side; slave is the requester/transceiver side.
interface ps2_cmd_scheduler_if #(
  parameter int unsigned NREQ = 3
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] cmd;
  logic [8*NREQ-1:0] arg;
  logic [NREQ-1:0]   has_arg;
  logic [NREQ-1:0]   done;
  logic              fail;
  logic              ps2clk_hold;
  logic              tx_start;
  logic [7:0]        tx_byte;
  logic              tx_done;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic              rx_busy;
  logic              scan_valid;
  logic [7:0]        scan_byte;

  modport master (
    input  req, cmd, arg, has_arg, tx_done, rx_valid, rx_byte, rx_busy,
    output done, fail, ps2clk_hold, tx_start, tx_byte, scan_valid, scan_byte
  );

  modport slave (
    output req, cmd, arg, has_arg, tx_done, rx_valid, rx_byte, rx_busy,
    input  done, fail, ps2clk_hold, tx_start, tx_byte, scan_valid, scan_byte
  );
endinterface

// File: rtl/ps2_cmd_scheduler.sv
// Round-robin arbiter and sequencer for host-to-keyboard PS/2 commands, with ACK/RESEND
// retry, timeouts and pass-through of unsolicited bytes as scancodes.
module ps2_cmd_scheduler #(
  parameter int unsigned NREQ      = 3,
  parameter int unsigned RTS_CYC   = 710,
  parameter int unsigned TMO_CYC   = 131072,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic                 clk_i,
  input  logic                 clk7_en_i,
  input  logic                 reset_ni,
  ps2_cmd_scheduler_if.master  bus
);

  localparam int unsigned IdxW     = (NREQ > 2) ? 2 : 1;
  localparam logic [17:0] RtsLast  = 18'(RTS_CYC - 1);
  localparam logic [17:0] TmoLast  = 18'(TMO_CYC - 1);
  localparam logic [3:0]  RetryMax = 4'(MAX_RETRY);
  localparam logic [7:0]  Ack      = 8'hFA;
  localparam logic [7:0]  Resend   = 8'hFE;

  typedef enum logic [2:0] {StIdle, StRts, StSend, StWaitTx, StWaitRsp, StDone} state_e;

  state_e            state_q;
  logic [17:0]       timer_q;
  logic [IdxW-1:0]   ptr_q, win_q;
  logic [7:0]        cmd_q, arg_q, tx_byte_q, scan_byte_q;
  logic              has_arg_q, phase_arg_q;
  logic [3:0]        retry_q;
  logic              hold_q, tx_start_q, fail_q, scan_valid_q;
  logic [NREQ-1:0]   done_q;

  logic              gnt_found, gnt_has_arg;
  logic [IdxW-1:0]   gnt_idx;
  logic [7:0]        gnt_cmd, gnt_arg;
  int                idx;

  // Descending scan so the requester closest after ptr_q is written last and wins.
  always_comb begin
    gnt_found   = 1'b0;
    gnt_idx     = '0;
    gnt_cmd     = '0;
    gnt_arg     = '0;
    gnt_has_arg = 1'b0;
    idx         = 0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % int'(NREQ);
      if (bus.req[idx]) begin
        gnt_found   = 1'b1;
        gnt_idx     = IdxW'(idx);
        gnt_cmd     = bus.cmd[8*idx +: 8];
        gnt_arg     = bus.arg[8*idx +: 8];
        gnt_has_arg = bus.has_arg[idx];
      end
    end
  end

  logic tmo, ack, next_arg, resend, can_retry, finish, fwd;

  always_comb begin
    tmo       = timer_q >= TmoLast;
    ack       = (state_q == StWaitRsp) && bus.rx_valid && (bus.rx_byte == Ack);
    next_arg  = !phase_arg_q && has_arg_q;
    resend    = ((state_q == StWaitTx) && !bus.tx_done && tmo) ||
                ((state_q == StWaitRsp) && (bus.rx_valid ? (bus.rx_byte == Resend) : tmo));
    can_retry = retry_q < RetryMax;
    finish    = (ack && !next_arg) || (resend && !can_retry);
    // ACK/RESEND are consumed only while a response is awaited.
    fwd       = bus.rx_valid && !((state_q == StWaitRsp) &&
                                  ((bus.rx_byte == Ack) || (bus.rx_byte == Resend)));
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      ptr_q        <= '0;
      win_q        <= '0;
      cmd_q        <= '0;
      arg_q        <= '0;
      has_arg_q    <= 1'b0;
      phase_arg_q  <= 1'b0;
      retry_q      <= '0;
      hold_q       <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_byte_q    <= '0;
      done_q       <= '0;
      fail_q       <= 1'b0;
      scan_valid_q <= 1'b0;
      scan_byte_q  <= '0;
    end else if (clk7_en_i) begin
      tx_start_q   <= 1'b0;
      done_q       <= '0;
      fail_q       <= 1'b0;
      scan_valid_q <= 1'b0;
      hold_q       <= (state_q == StRts);
      if (timer_q != '1) timer_q <= timer_q + 1'b1;
      if (fwd) begin
        scan_valid_q <= 1'b1;
        scan_byte_q  <= bus.rx_byte;
      end
      unique case (state_q)
        StIdle: begin
          if (gnt_found && !bus.rx_busy) begin
            win_q       <= gnt_idx;
            cmd_q       <= gnt_cmd;
            arg_q       <= gnt_arg;
            has_arg_q   <= gnt_has_arg;
            phase_arg_q <= 1'b0;
            retry_q     <= '0;
            state_q     <= StRts;
            timer_q     <= '0;
          end
        end
        StRts: begin
          if (timer_q >= RtsLast) begin
            state_q <= StSend;
            timer_q <= '0;
          end
        end
        StSend: begin
          tx_start_q <= 1'b1;
          tx_byte_q  <= phase_arg_q ? arg_q : cmd_q;
          state_q    <= StWaitTx;
          timer_q    <= '0;
        end
        StWaitTx: begin
          if (bus.tx_done) begin
            state_q <= StWaitRsp;
            timer_q <= '0;
          end
        end
        StWaitRsp: begin
          if (ack && next_arg) begin
            phase_arg_q <= 1'b1;
            retry_q     <= '0;
            state_q     <= StRts;
            timer_q     <= '0;
          end
        end
        StDone: begin
          ptr_q   <= (win_q == IdxW'(NREQ - 1)) ? '0 : win_q + 1'b1;
          state_q <= StIdle;
          timer_q <= '0;
        end
        default: begin
          state_q <= StIdle;
          timer_q <= '0;
        end
      endcase
      if (resend && can_retry) begin
        retry_q <= retry_q + 1'b1;
        state_q <= StRts;
        timer_q <= '0;
      end
      if (finish) begin
        state_q       <= StDone;
        timer_q       <= '0;
        done_q[win_q] <= 1'b1;
        fail_q        <= !ack;
      end
    end
  end

  assign bus.done        = done_q;
  assign bus.fail        = fail_q;
  assign bus.ps2clk_hold = hold_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_byte     = tx_byte_q;
  assign bus.scan_valid  = scan_valid_q;
  assign bus.scan_byte   = scan_byte_q;

endmodule

// File: tb/tb_ps2_cmd_scheduler.sv
// Scoreboard bench for ps2_cmd_scheduler: a keyboard model answers each sent byte, a monitor
// checks sent bytes, done/fail pulses, scancodes and RTS window lengths against queues.
module tb_ps2_cmd_scheduler;
  localparam int unsigned NREQ = 3;
  localparam int unsigned RTS  = 710;
  localparam int unsigned TMO  = 1500;
  localparam int unsigned MAXR = 2;

  typedef struct packed {
    logic       silent;
    logic       has_pre;
    logic [7:0] pre;
    logic [7:0] main;
  } rsp_t;

  localparam rsp_t RAck    = '{silent: 1'b0, has_pre: 1'b0, pre: 8'h00, main: 8'hFA};
  localparam rsp_t RResend = '{silent: 1'b0, has_pre: 1'b0, pre: 8'h00, main: 8'hFE};
  localparam rsp_t RSilent = '{silent: 1'b1, has_pre: 1'b0, pre: 8'h00, main: 8'h00};
  localparam rsp_t RPreAck = '{silent: 1'b0, has_pre: 1'b1, pre: 8'h32, main: 8'hFA};

  logic clk = 1'b0;
  logic clk7_en = 1'b1;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ps2_cmd_scheduler_if #(.NREQ(NREQ)) bus ();

  ps2_cmd_scheduler #(
    .NREQ(NREQ), .RTS_CYC(RTS), .TMO_CYC(TMO), .MAX_RETRY(MAXR)
  ) dut (
    .clk_i(clk),
    .clk7_en_i(clk7_en),
    .reset_ni(reset_n),
    .bus(bus)
  );

  logic       dev_rx_v, stim_rx_v;
  logic [7:0] dev_rx_b, stim_rx_b;
  assign bus.rx_valid = dev_rx_v | stim_rx_v;
  assign bus.rx_byte  = dev_rx_v ? dev_rx_b : stim_rx_b;

  logic [7:0]  exp_tx[$];
  logic [3:0]  exp_done[$];  // {done[2:0], fail}
  logic [7:0]  exp_scan[$];
  rsp_t        rsp_q[$];

  int checks = 0;
  int errors = 0;
  int hold_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h with nothing expected", name, act);
  endtask

  // Keyboard model: acknowledge the frame, then reply with the next queued response.
  initial begin
    rsp_t r;
    bus.tx_done = 1'b0;
    dev_rx_v    = 1'b0;
    dev_rx_b    = '0;
    forever begin
      @(negedge clk);
      if (reset_n && bus.tx_start) begin
        repeat (4) @(negedge clk);
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        repeat (8) @(negedge clk);
        if (rsp_q.size() != 0) begin
          r = rsp_q.pop_front();
          if (r.has_pre) begin
            dev_rx_b = r.pre;
            dev_rx_v = 1'b1;
            @(negedge clk);
            dev_rx_v = 1'b0;
            repeat (4) @(negedge clk);
          end
          if (!r.silent) begin
            dev_rx_b = r.main;
            dev_rx_v = 1'b1;
            @(negedge clk);
            dev_rx_v = 1'b0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      hold_run = 0;
    end else if (bus.ps2clk_hold) begin
      hold_run++;
    end else if (hold_run != 0) begin
      chk("hold_len", hold_run, RTS);
      hold_run = 0;
    end
    if (bus.tx_start) begin
      if (exp_tx.size() == 0) unexpected("tx_start", bus.tx_byte);
      else chk("tx_byte", bus.tx_byte, exp_tx.pop_front());
    end
    if (bus.done != '0) begin
      if (exp_done.size() == 0) unexpected("done", {bus.done, bus.fail});
      else chk("done_fail", {bus.done, bus.fail}, exp_done.pop_front());
    end else if (bus.fail) begin
      unexpected("fail_without_done", bus.fail);
    end
    if (bus.scan_valid) begin
      if (exp_scan.size() == 0) unexpected("scan", bus.scan_byte);
      else chk("scan_byte", bus.scan_byte, exp_scan.pop_front());
    end
  end

  task automatic wait_done(input int n);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (bus.done != '0) got++;
    end
    if (got < n) chk("done_timeout", got, n);
    bus.req = '0;
  endtask

  initial begin
    int cyc;
    bus.req     = '0;
    bus.cmd     = '0;
    bus.arg     = '0;
    bus.has_arg = '0;
    bus.rx_busy = 1'b0;
    stim_rx_v   = 1'b0;
    stim_rx_b   = '0;
    repeat (3) @(negedge clk);
    chk("rst_hold", bus.ps2clk_hold, 0);
    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_tx_byte", bus.tx_byte, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_fail", bus.fail, 0);
    chk("rst_scan_valid", bus.scan_valid, 0);
    chk("rst_scan_byte", bus.scan_byte, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single no-arg command to requester 1; two-tick req-to-hold latency.
    bus.cmd = {8'h00, 8'hF4, 8'h00};
    exp_tx.push_back(8'hF4);
    exp_done.push_back({3'b010, 1'b0});
    rsp_q.push_back(RAck);
    bus.req = 3'b010;
    @(negedge clk);
    chk("hold_lat1", bus.ps2clk_hold, 0);
    @(negedge clk);
    chk("hold_lat2", bus.ps2clk_hold, 1);
    wait_done(1);

    // Command with argument, both bytes acknowledged.
    bus.cmd     = {8'h00, 8'h00, 8'hED};
    bus.arg     = {8'h00, 8'h00, 8'h05};
    bus.has_arg = 3'b001;
    exp_tx.push_back(8'hED);
    exp_tx.push_back(8'h05);
    exp_done.push_back({3'b001, 1'b0});
    rsp_q.push_back(RAck);
    rsp_q.push_back(RAck);
    bus.req = 3'b001;
    wait_done(1);

    // Three RESENDs exhaust retries; the argument is never sent.
    bus.cmd     = {8'hED, 8'h00, 8'h00};
    bus.arg     = {8'h77, 8'h00, 8'h00};
    bus.has_arg = 3'b100;
    for (int i = 0; i < 3; i++) begin
      exp_tx.push_back(8'hED);
      rsp_q.push_back(RResend);
    end
    exp_done.push_back({3'b100, 1'b1});
    bus.req = 3'b100;
    wait_done(1);

    // All requesting at once: served 0,1,2,0.
    bus.cmd     = {8'hF6, 8'hF5, 8'hF4};
    bus.arg     = '0;
    bus.has_arg = '0;
    exp_tx.push_back(8'hF4);
    exp_tx.push_back(8'hF5);
    exp_tx.push_back(8'hF6);
    exp_tx.push_back(8'hF4);
    exp_done.push_back({3'b001, 1'b0});
    exp_done.push_back({3'b010, 1'b0});
    exp_done.push_back({3'b100, 1'b0});
    exp_done.push_back({3'b001, 1'b0});
    for (int i = 0; i < 4; i++) rsp_q.push_back(RAck);
    bus.req = 3'b111;
    wait_done(4);

    // Scancode pass-through in IDLE and WAIT_RSP; the ACK itself is consumed.
    exp_scan.push_back(8'h1C);
    stim_rx_b = 8'h1C;
    stim_rx_v = 1'b1;
    @(negedge clk);
    stim_rx_v = 1'b0;
    repeat (3) @(negedge clk);
    bus.cmd = {8'h00, 8'hF4, 8'h00};
    exp_scan.push_back(8'h32);
    exp_tx.push_back(8'hF4);
    exp_done.push_back({3'b010, 1'b0});
    rsp_q.push_back(RPreAck);
    bus.req = 3'b010;
    wait_done(1);

    // No response at all: response timeout counts as a resend.
    bus.cmd = {8'hF4, 8'h00, 8'h00};
    for (int i = 0; i < 3; i++) begin
      exp_tx.push_back(8'hF4);
      rsp_q.push_back(RSilent);
    end
    exp_done.push_back({3'b100, 1'b1});
    bus.req = 3'b100;
    wait_done(1);

    // Leave the pointer at 1 before the reset test.
    bus.cmd = {8'h00, 8'h00, 8'hF5};
    exp_tx.push_back(8'hF5);
    exp_done.push_back({3'b001, 1'b0});
    rsp_q.push_back(RAck);
    bus.req = 3'b001;
    wait_done(1);

    // Reset in the middle of RTS: hold drops at once, no done, pointer back to 0.
    bus.cmd = {8'hF6, 8'h00, 8'hF4};
    bus.req = 3'b100;
    cyc = 0;
    while (!bus.ps2clk_hold && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("rts_reached", bus.ps2clk_hold, 1);
    repeat (100) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_hold_release", bus.ps2clk_hold, 0);
    chk("async_done", bus.done, 0);
    bus.req = 3'b101;
    exp_tx.push_back(8'hF4);
    exp_tx.push_back(8'hF6);
    exp_done.push_back({3'b001, 1'b0});
    exp_done.push_back({3'b100, 1'b0});
    rsp_q.push_back(RAck);
    rsp_q.push_back(RAck);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    wait_done(2);

    cyc = 0;
    while ((exp_tx.size() + exp_done.size() + exp_scan.size() + rsp_q.size()) != 0 &&
           cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (20) @(negedge clk);
    chk("tx_queue_drained", exp_tx.size(), 0);
    chk("done_queue_drained", exp_done.size(), 0);
    chk("scan_queue_drained", exp_scan.size(), 0);
    chk("rsp_queue_drained", rsp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
